// File: rtl/prbs_checker.sv
// Receive-side checker for the x^2+x+1 PRBS stream: self-seeds from two bits,
// then predicts each bit, flags mismatches and keeps saturating bit/error counts.
module prbs_checker #(
  parameter int CW          = 16,
  parameter int LOSS_THRESH = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic          in,
  input  logic          clr_counts,
  output logic          locked,
  output logic          err,
  output logic [CW-1:0] err_count,
  output logic [CW-1:0] bit_count
);

  typedef enum logic [1:0] {
    SEEK0  = 2'd0,
    SEEK1  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [2:0]    THRESH_C  = 3'(LOSS_THRESH);
  localparam logic [CW-1:0] CNT_MAX_C = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE_C = CW'(1'b1);

  state_t        state_r, state_s;
  logic          r0_r, r1_r, r0_s, r1_s, pred_s;
  logic [2:0]    miss_r, miss_s;
  logic          cnt_bit_s, cnt_err_s, err_s;
  logic          locked_r, err_r;
  logic [CW-1:0] err_count_r, bit_count_r;

  // Next-state, history and count-strobe logic for one accepted bit.
  always_comb begin
    state_s   = state_r;
    r0_s      = r0_r;
    r1_s      = r1_r;
    miss_s    = miss_r;
    pred_s    = r0_r ^ r1_r;
    cnt_bit_s = 1'b0;
    cnt_err_s = 1'b0;
    err_s     = 1'b0;
    if (ena) begin
      case (state_r)
        SEEK0: begin
          r0_s    = in;
          state_s = SEEK1;
        end
        SEEK1: begin
          r1_s = r0_r;
          r0_s = in;
          // An all-zero seed pair would predict zeros forever, so keep seeking.
          if (!r0_r && !in) begin
            state_s = SEEK1;
          end else begin
            state_s = LOCKED;
          end
        end
        LOCKED: begin
          // The prediction, not the received bit, enters history so one flip stays isolated.
          r1_s      = r0_r;
          r0_s      = pred_s;
          cnt_bit_s = 1'b1;
          if (in == pred_s) begin
            miss_s = 3'd0;
          end else begin
            err_s     = 1'b1;
            cnt_err_s = 1'b1;
            if ((miss_r + 3'd1) == THRESH_C) begin
              miss_s  = 3'd0;
              state_s = SEEK0;
            end else begin
              miss_s = miss_r + 3'd1;
            end
          end
        end
        default: begin
          state_s = SEEK0;
          miss_s  = 3'd0;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // State, history and status output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= SEEK0;
      r0_r     <= 1'b0;
      r1_r     <= 1'b0;
      miss_r   <= 3'd0;
      locked_r <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      state_r  <= state_s;
      r0_r     <= r0_s;
      r1_r     <= r1_s;
      miss_r   <= miss_s;
      locked_r <= (state_s == LOCKED);
      err_r    <= err_s;
    end
  end

  // Saturating counters; clr_counts overrides a bit counted on the same edge.
  always_ff @(posedge clk) begin
    if (rst || clr_counts) begin
      bit_count_r <= {CW{1'b0}};
      err_count_r <= {CW{1'b0}};
    end else begin
      if (cnt_bit_s && (bit_count_r != CNT_MAX_C)) begin
        bit_count_r <= bit_count_r + CNT_ONE_C;
      end else begin
        bit_count_r <= bit_count_r;
      end
      if (cnt_err_s && (err_count_r != CNT_MAX_C)) begin
        err_count_r <= err_count_r + CNT_ONE_C;
      end else begin
        err_count_r <= err_count_r;
      end
    end
  end

  assign locked    = locked_r;
  assign err       = err_r;
  assign err_count = err_count_r;
  assign bit_count = bit_count_r;

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: two instances (CW=16/thresh 3 and CW=2/thresh 1) driven
// together and compared every cycle against a queue-based stream model.
module tb_prbs_checker;

  logic        clk = 1'b0;
  logic        rst, ena, din, clr;
  logic        lk0, er0, lk1, er1;
  logic [15:0] ec0, bc0;
  logic [1:0]  ec1, bc1;

  int tests  = 0;
  int failed = 0;
  bit chk_on = 1'b0;
  int ph     = 0;

  always #5 clk = ~clk;

  prbs_checker #(.CW(16), .LOSS_THRESH(3)) dut0 (
    .clk(clk), .rst(rst), .ena(ena), .in(din), .clr_counts(clr),
    .locked(lk0), .err(er0), .err_count(ec0), .bit_count(bc0));

  prbs_checker #(.CW(2), .LOSS_THRESH(1)) dut1 (
    .clk(clk), .rst(rst), .ena(ena), .in(din), .clr_counts(clr),
    .locked(lk1), .err(er1), .err_count(ec1), .bit_count(bc1));

  // Reference model: per instance, the last two stream bits as a queue, plain int counts.
  int m_thr [2] = '{3, 1};
  int m_max [2] = '{65535, 3};
  bit m_lock[2];
  bit m_err [2];
  int m_miss[2];
  int m_bc  [2];
  int m_ec  [2];
  bit m_hist[2][$];

  task automatic model_step(input int i);
    bit counted, miss, p;
    counted = 1'b0;
    miss    = 1'b0;
    if (rst) begin
      m_lock[i] = 1'b0; m_err[i] = 1'b0; m_miss[i] = 0;
      m_bc[i] = 0; m_ec[i] = 0;
      m_hist[i].delete();
      return;
    end
    if (ena) begin
      if (!m_lock[i]) begin
        m_hist[i].push_back(din);
        if (m_hist[i].size() > 2) void'(m_hist[i].pop_front());
        if (m_hist[i].size() == 2 && (m_hist[i][0] | m_hist[i][1])) m_lock[i] = 1'b1;
      end else begin
        p       = m_hist[i][0] ^ m_hist[i][1];
        counted = 1'b1;
        miss    = (din != p);
        m_hist[i].push_back(p);
        void'(m_hist[i].pop_front());
        m_miss[i] = miss ? m_miss[i] + 1 : 0;
        if (m_miss[i] == m_thr[i]) begin
          m_lock[i] = 1'b0;
          m_miss[i] = 0;
          m_hist[i].delete();
        end
      end
    end
    m_err[i] = miss;
    if (clr) begin
      m_bc[i] = 0;
      m_ec[i] = 0;
    end else begin
      if (counted && m_bc[i] < m_max[i]) m_bc[i]++;
      if (miss && m_ec[i] < m_max[i]) m_ec[i]++;
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) model_step(i);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("locked0", 32'(lk0), 32'(m_lock[0]));
      chk("err0",    32'(er0), 32'(m_err[0]));
      chk("bc0",     32'(bc0), 32'(m_bc[0]));
      chk("ec0",     32'(ec0), 32'(m_ec[0]));
      chk("locked1", 32'(lk1), 32'(m_lock[1]));
      chk("err1",    32'(er1), 32'(m_err[1]));
      chk("bc1",     32'(bc1), 32'(m_bc[1]));
      chk("ec1",     32'(ec1), 32'(m_ec[1]));
    end
  end

  function automatic logic pat(input int k);
    return (k % 3) != 2;
  endfunction

  task automatic send(input logic b, input logic e, input logic c);
    ena = e;
    din = b;
    clr = c;
    @(negedge clk);
  endtask

  task automatic nxt(input logic flip);
    send(pat(ph) ^ flip, 1'b1, 1'b0);
    ph++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    send(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    ph  = 0;
  endtask

  initial begin
    int noise;
    logic bitv, e, c;
    rst = 1'b1; ena = 1'b0; din = 1'b0; clr = 1'b0;
    @(negedge clk);
    chk_on = 1'b1;
    chk("rst_locked", 32'(lk0), 32'd0);
    chk("rst_err",    32'(er0), 32'd0);
    chk("rst_bc",     32'(bc0), 32'd0);
    chk("rst_ec",     32'(ec0), 32'd0);
    rst = 1'b0;
    ph  = 0;

    // Clean 1,1,0 stream for 20 bits.
    for (int k = 0; k < 20; k++) begin
      nxt(1'b0);
      if (k == 0) chk("unlocked_after_1", 32'(lk0), 32'd0);
      if (k == 1) chk("locked_after_2", 32'(lk0), 32'd1);
    end
    chk("clean_bc18", 32'(bc0), 32'd18);
    chk("clean_ec0",  32'(ec0), 32'd0);

    // Flip the 5th bit of an aligned 1,1,0,1,1,0 segment.
    nxt(1'b0);
    for (int k = 0; k < 4; k++) nxt(1'b0);
    nxt(1'b1);
    chk("flip_err",    32'(er0), 32'd1);
    chk("flip_ec1",    32'(ec0), 32'd1);
    chk("flip_locked", 32'(lk0), 32'd1);
    for (int k = 0; k < 6; k++) nxt(1'b0);
    chk("after_flip_ec", 32'(ec0), 32'd1);

    // Zeros never lock; the first 1 does.
    do_reset();
    for (int k = 0; k < 4; k++) send(1'b0, 1'b1, 1'b0);
    chk("zeros_unlocked", 32'(lk0), 32'd0);
    nxt(1'b0);
    chk("lock_on_first_1", 32'(lk0), 32'd1);
    for (int k = 0; k < 3; k++) nxt(1'b0);
    chk("zeros_bc3", 32'(bc0), 32'd3);
    chk("zeros_ec0", 32'(ec0), 32'd0);

    // Three consecutive misses drop lock; counts hold while re-seeking.
    for (int k = 0; k < 3; k++) begin
      nxt(1'b1);
      chk("loss_err", 32'(er0), 32'd1);
      chk("loss_locked", 32'(lk0), (k == 2) ? 32'd0 : 32'd1);
    end
    chk("loss_ec3", 32'(ec0), 32'd3);
    chk("loss_bc6", 32'(bc0), 32'd6);
    nxt(1'b0);
    chk("reseek_1", 32'(lk0), 32'd0);
    nxt(1'b0);
    chk("relock_2", 32'(lk0), 32'd1);
    chk("reseek_bc_held", 32'(bc0), 32'd6);

    // Alternating ena is transparent.
    do_reset();
    for (int k = 0; k < 24; k++) begin
      if (k % 2 == 0) begin
        send(pat(ph), 1'b1, 1'b0);
        ph++;
      end else begin
        send(($urandom_range(0, 1) == 1), 1'b0, 1'b0);
      end
    end
    chk("gap_bc10",   32'(bc0), 32'd10);
    chk("gap_ec0",    32'(ec0), 32'd0);
    chk("gap_locked", 32'(lk0), 32'd1);

    // Five isolated errors: CW=2 saturates at 3.
    do_reset();
    for (int k = 0; k < 3; k++) nxt(1'b0);
    for (int n = 0; n < 5; n++) begin
      nxt(1'b1);
      for (int k = 0; k < 4; k++) nxt(1'b0);
    end
    chk("sat_ec1_3", 32'(ec1), 32'd3);
    chk("sat_bc1_3", 32'(bc1), 32'd3);
    chk("sat_ec0_5", 32'(ec0), 32'd5);

    // clr_counts beats a counted bit on the same edge.
    send(pat(ph), 1'b1, 1'b1);
    ph++;
    chk("clr_bc0", 32'(bc0), 32'd0);
    chk("clr_ec0", 32'(ec0), 32'd0);
    chk("clr_bc1", 32'(bc1), 32'd0);
    chk("clr_ec1", 32'(ec1), 32'd0);
    nxt(1'b0);
    chk("after_clr_bc1", 32'(bc0), 32'd1);

    // Reset mid-stream, together with a mismatching bit.
    nxt(1'b1);
    rst = 1'b1;
    send(~pat(ph), 1'b1, 1'b0);
    rst = 1'b0;
    chk("midrst_locked", 32'(lk0), 32'd0);
    chk("midrst_err",    32'(er0), 32'd0);
    chk("midrst_ec",     32'(ec0), 32'd0);
    chk("midrst_bc",     32'(bc0), 32'd0);
    ph = 0;

    // Randomized traffic: sparse flips, noise bursts, ena gaps, clears, resets.
    noise = 0;
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 149) == 0);
      if (rst) ph = int'($urandom_range(0, 2));
      if (noise == 0 && $urandom_range(0, 199) == 0) noise = int'($urandom_range(1, 8));
      if (noise > 0) bitv = ($urandom_range(0, 1) == 1);
      else           bitv = pat(ph) ^ ($urandom_range(0, 15) == 0);
      e = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 63) == 0);
      send(bitv, e, c);
      if (e) begin
        ph++;
        if (noise > 0) noise--;
      end
    end
    rst = 1'b0;
    send(1'b0, 1'b0, 1'b0);

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
